// File: rtl/cache_assoc_wb_pkg.sv
// Shared types for the write-back set-associative data cache: core access
// encodings, miss FSM states and the alignment rule.
package cache_assoc_wb_pkg;

    typedef enum logic [2:0] {
        CACHE_RD_NO,
        CACHE_RD_B,
        CACHE_RD_BU,
        CACHE_RD_H,
        CACHE_RD_HU,
        CACHE_RD_W
    } CacheRdControl;

    typedef enum logic [1:0] {
        CACHE_WR_NO,
        CACHE_WR_B,
        CACHE_WR_H,
        CACHE_WR_W
    } CacheWrControl;

    typedef enum logic [1:0] {
        CACHE_IDLE,
        CACHE_WRITEBACK,
        CACHE_REFILL
    } CacheFsmState;

    // Half accesses need an even address, word accesses a 4-aligned one.
    function automatic logic misaligned_access(CacheRdControl rd, CacheWrControl wr,
                                               logic [1:0] off);
        logic half;
        logic word;
        half = (rd == CACHE_RD_H) || (rd == CACHE_RD_HU) || (wr == CACHE_WR_H);
        word = (rd == CACHE_RD_W) || (wr == CACHE_WR_W);
        return (half && off[0]) || (word && (off != 2'b00));
    endfunction

endpackage

// File: rtl/cache_byte_lane.sv
// Combinational load extract/extend and store byte merge on one cached word.
module cache_byte_lane
    import cache_assoc_wb_pkg::*;
(
    input  CacheRdControl rd_type,
    input  CacheWrControl wr_en,
    input  logic [1:0]    byte_off,
    input  logic [31:0]   line_word,
    input  logic [31:0]   wr_data,
    output logic [31:0]   rd_data,
    output logic [31:0]   merged
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = line_word[{byte_off, 3'b000} +: 8];
        sel_half = byte_off[1] ? line_word[31:16] : line_word[15:0];
        case (rd_type)
            CACHE_RD_B:  rd_data = {{24{sel_byte[7]}}, sel_byte};
            CACHE_RD_BU: rd_data = {24'h0, sel_byte};
            CACHE_RD_H:  rd_data = {{16{sel_half[15]}}, sel_half};
            CACHE_RD_HU: rd_data = {16'h0, sel_half};
            CACHE_RD_W:  rd_data = line_word;
            default:     rd_data = '0;
        endcase
    end

    always_comb begin
        merged = line_word;
        case (wr_en)
            CACHE_WR_B: merged[{byte_off, 3'b000} +: 8] = wr_data[7:0];
            CACHE_WR_H: begin
                if (byte_off[1]) merged[31:16] = wr_data[15:0];
                else             merged[15:0]  = wr_data[15:0];
            end
            CACHE_WR_W: merged = wr_data;
            default:    merged = line_word;
        endcase
    end

endmodule

// File: rtl/cache_assoc_wb.sv
// N-way set-associative write-back/write-allocate data cache with a miss FSM
// that writes back a dirty victim and refills the line one bus word at a time.
module cache_assoc_wb
    import cache_assoc_wb_pkg::*;
#(
    parameter int CACHE_SIZE = 1024,
    parameter int WAYS       = 2,
    parameter int LINE_WORDS = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  CacheRdControl rd_type_in,
    input  CacheWrControl wr_en_in,
    input  logic [31:0]   addr_in,
    input  logic [31:0]   wr_data_in,
    output logic [31:0]   rd_data_out,
    output logic          cache_stall,
    output logic          misaligned,
    output logic          mem_req,
    output logic          mem_we,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wr_data,
    input  logic          mem_ack,
    input  logic [31:0]   mem_rd_data
);

    localparam int SETS  = CACHE_SIZE / (WAYS * LINE_WORDS * 4);
    localparam int IDX_W = $clog2(SETS);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int TAG_W = 30 - IDX_W - OFF_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [OFF_W-1:0] word_sel;
    logic [1:0]       byte_off;

    assign {tag, idx, word_sel, byte_off} = addr_in;

    CacheFsmState     state_q, state_d;
    logic [OFF_W-1:0] cnt_q;
    logic [WAY_W-1:0] victim_q, victim;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] ptr_q [SETS];

    logic [WAYS-1:0]  way_hit, way_valid, way_dirty;
    logic [TAG_W-1:0] way_tag [WAYS];
    logic [31:0]      way_word [WAYS];
    logic [31:0]      way_wb_word [WAYS];

    logic        access, access_ok, hit, miss;
    logic        hit_wr, xfer, last_word, fill_we, fill_done;
    logic [31:0] lane_rd, merged;

    assign access    = (rd_type_in != CACHE_RD_NO) || (wr_en_in != CACHE_WR_NO);
    assign misaligned = misaligned_access(rd_type_in, wr_en_in, byte_off);
    assign access_ok = access && !misaligned;
    assign hit       = |way_hit;
    assign miss      = access_ok && !hit;

    assign hit_wr    = (state_q == CACHE_IDLE) && access_ok && hit && (wr_en_in != CACHE_WR_NO);
    assign mem_req   = (state_q != CACHE_IDLE);
    assign mem_we    = (state_q == CACHE_WRITEBACK);
    assign xfer      = mem_req && mem_ack;
    assign last_word = &cnt_q;
    assign fill_we   = (state_q == CACHE_REFILL) && xfer;
    assign fill_done = fill_we && last_word;

    // Stall is forced low while reset is held so an aborted miss releases the core at once.
    assign cache_stall = reset_n && ((state_q != CACHE_IDLE) || miss);

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        logic [TAG_W-1:0] tags [SETS];
        logic [SETS-1:0]  valid;
        logic [SETS-1:0]  dirty;
        logic [31:0]      data [SETS][LINE_WORDS];
        logic             sel_hit, sel_fill;

        assign sel_hit  = hit_wr && (hit_way == WAY_W'(w));
        assign sel_fill = fill_we && (victim_q == WAY_W'(w));

        assign way_hit[w]     = valid[idx] && (tags[idx] == tag);
        assign way_valid[w]   = valid[idx];
        assign way_dirty[w]   = dirty[idx];
        assign way_tag[w]     = tags[idx];
        assign way_word[w]    = data[idx][word_sel];
        assign way_wb_word[w] = data[idx][cnt_q];

        always_ff @(posedge clk) begin
            if (sel_hit)
                data[idx][word_sel] <= merged;
            else if (sel_fill)
                data[idx][cnt_q] <= mem_rd_data;
            if (sel_fill && last_word)
                tags[idx] <= tag;
        end

        // Valid only rises on the final refill word, so an aborted fill stays invalid.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                valid <= '0;
                dirty <= '0;
            end else if (sel_fill && last_word) begin
                valid[idx] <= 1'b1;
                dirty[idx] <= 1'b0;
            end else if (sel_hit) begin
                dirty[idx] <= 1'b1;
            end
        end
    end

    always_comb begin
        hit_way = '0;
        for (int w = 0; w < WAYS; w++)
            if (way_hit[w]) hit_way = WAY_W'(w);
    end

    // Lowest-numbered invalid way wins; otherwise the per-set round-robin pointer.
    always_comb begin
        logic found;
        found  = 1'b0;
        victim = ptr_q[idx];
        for (int w = 0; w < WAYS; w++) begin
            if (!way_valid[w] && !found) begin
                victim = WAY_W'(w);
                found  = 1'b1;
            end
        end
    end

    cache_byte_lane u_lane (
        .rd_type   (rd_type_in),
        .wr_en     (wr_en_in),
        .byte_off  (byte_off),
        .line_word (way_word[hit_way]),
        .wr_data   (wr_data_in),
        .rd_data   (lane_rd),
        .merged    (merged)
    );

    assign rd_data_out = ((state_q == CACHE_IDLE) && access_ok && hit &&
                          (rd_type_in != CACHE_RD_NO)) ? lane_rd : 32'h0;

    always_comb begin
        mem_addr    = {tag, idx, cnt_q, 2'b00};
        mem_wr_data = 32'h0;
        if (state_q == CACHE_WRITEBACK) begin
            mem_addr    = {way_tag[victim_q], idx, cnt_q, 2'b00};
            mem_wr_data = way_wb_word[victim_q];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            CACHE_IDLE:
                if (miss)
                    state_d = (way_valid[victim] && way_dirty[victim]) ? CACHE_WRITEBACK
                                                                       : CACHE_REFILL;
            CACHE_WRITEBACK:
                if (xfer && last_word) state_d = CACHE_REFILL;
            CACHE_REFILL:
                if (xfer && last_word) state_d = CACHE_IDLE;
            default:
                state_d = CACHE_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= CACHE_IDLE;
            cnt_q    <= '0;
            victim_q <= '0;
        end else begin
            state_q <= state_d;
            if (xfer)
                cnt_q <= cnt_q + 1'b1;
            if (state_q == CACHE_IDLE)
                victim_q <= victim;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SETS; s++)
                ptr_q[s] <= '0;
        end else if (fill_done) begin
            ptr_q[idx] <= (ptr_q[idx] == WAY_W'(WAYS - 1)) ? '0 : ptr_q[idx] + 1'b1;
        end
    end

endmodule

// File: tb/tb_cache_assoc_wb.sv
// Directed bench for cache_assoc_wb: miss/refill, hits with byte merge,
// dirty eviction, misalignment, reset abort and read-before-write.
module tb_cache_assoc_wb;
    import cache_assoc_wb_pkg::*;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    CacheRdControl rd_type_in = CACHE_RD_NO;
    CacheWrControl wr_en_in = CACHE_WR_NO;
    logic [31:0]   addr_in = '0;
    logic [31:0]   wr_data_in = '0;
    logic [31:0]   rd_data_out;
    logic          cache_stall, misaligned;
    logic          mem_req, mem_we;
    logic [31:0]   mem_addr, mem_wr_data;
    logic          mem_ack = 1'b0;
    logic [31:0]   mem_rd_data;

    int passed = 0;
    int total  = 0;

    logic [31:0] log_addr[$];
    logic        log_we[$];
    logic [31:0] log_data[$];

    cache_assoc_wb dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rd_type_in  (rd_type_in),
        .wr_en_in    (wr_en_in),
        .addr_in     (addr_in),
        .wr_data_in  (wr_data_in),
        .rd_data_out (rd_data_out),
        .cache_stall (cache_stall),
        .misaligned  (misaligned),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_ack     (mem_ack),
        .mem_rd_data (mem_rd_data)
    );

    always #5 clk = ~clk;

    // Bus: acks every other cycle; the transfer logged here completes at the next posedge.
    assign mem_rd_data = 32'h1000_0000 + mem_addr;
    always @(negedge clk) begin
        if (mem_req && !mem_ack) begin
            mem_ack = 1'b1;
            log_addr.push_back(mem_addr);
            log_we.push_back(mem_we);
            log_data.push_back(mem_wr_data);
        end else begin
            mem_ack = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    task automatic drive(CacheRdControl rd, CacheWrControl wr, logic [31:0] a, logic [31:0] d);
        @(negedge clk);
        rd_type_in = rd;
        wr_en_in   = wr;
        addr_in    = a;
        wr_data_in = d;
        #1;
    endtask

    task automatic wait_ready(string tag);
        int n = 0;
        while (cache_stall && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(tag, {31'h0, cache_stall}, 32'h0);
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_we.delete();
        log_data.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("rst_stall", {31'h0, cache_stall}, 32'h0);
        check("rst_req", {31'h0, mem_req}, 32'h0);
        check("rst_rd", rd_data_out, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // 1: cold miss, 4 refill reads
        clear_log();
        drive(CACHE_RD_W, CACHE_WR_NO, 32'h384, 32'h0);
        check("t1_stall", {31'h0, cache_stall}, 32'h1);
        wait_ready("t1_ready");
        check("t1_rd", rd_data_out, 32'h1000_0384);
        check("t1_nxfer", log_addr.size(), 32'd4);
        for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
            check("t1_addr", log_addr[i], 32'h380 + 32'(4 * i));
            check("t1_we", {31'h0, log_we[i]}, 32'h0);
        end

        // 2: byte store hit then loads
        drive(CACHE_RD_NO, CACHE_WR_B, 32'h387, 32'hAABB_CCDD);
        check("t2_wstall", {31'h0, cache_stall}, 32'h0);
        check("t2_wmis", {31'h0, misaligned}, 32'h0);
        drive(CACHE_RD_W, CACHE_WR_NO, 32'h384, 32'h0);
        check("t2_w", rd_data_out, 32'hDD00_0384);
        check("t2_wstall2", {31'h0, cache_stall}, 32'h0);
        drive(CACHE_RD_B, CACHE_WR_NO, 32'h387, 32'h0);
        check("t2_b", rd_data_out, 32'hFFFF_FFDD);
        drive(CACHE_RD_BU, CACHE_WR_NO, 32'h387, 32'h0);
        check("t2_bu", rd_data_out, 32'h0000_00DD);

        // 3: fill way1, then evict dirty way0
        clear_log();
        drive(CACHE_RD_W, CACHE_WR_NO, 32'h584, 32'h0);
        check("t3a_stall", {31'h0, cache_stall}, 32'h1);
        wait_ready("t3a_ready");
        check("t3a_rd", rd_data_out, 32'h1000_0584);
        check("t3a_nxfer", log_addr.size(), 32'd4);
        check("t3a_we", {31'h0, log_we[0]}, 32'h0);
        clear_log();
        drive(CACHE_RD_W, CACHE_WR_NO, 32'h784, 32'h0);
        wait_ready("t3b_ready");
        check("t3b_rd", rd_data_out, 32'h1000_0784);
        check("t3b_nxfer", log_addr.size(), 32'd8);
        for (int i = 0; i < 8 && i < log_addr.size(); i++) begin
            check("t3b_addr", log_addr[i], (i < 4) ? 32'h380 + 32'(4 * i) : 32'h780 + 32'(4 * (i - 4)));
            check("t3b_we", {31'h0, log_we[i]}, (i < 4) ? 32'h1 : 32'h0);
        end
        if (log_addr.size() >= 2) begin
            check("t3b_wb0", log_data[0], 32'h1000_0380);
            check("t3b_wb1", log_data[1], 32'hDD00_0384);
        end

        // 4: misaligned accesses change nothing
        clear_log();
        drive(CACHE_RD_NO, CACHE_WR_W, 32'h387, 32'h1234_5678);
        check("t4_mis", {31'h0, misaligned}, 32'h1);
        check("t4_stall", {31'h0, cache_stall}, 32'h0);
        check("t4_req", {31'h0, mem_req}, 32'h0);
        drive(CACHE_RD_NO, CACHE_WR_W, 32'h786, 32'h1234_5678);
        check("t4_mis2", {31'h0, misaligned}, 32'h1);
        drive(CACHE_RD_W, CACHE_WR_NO, 32'h784, 32'h0);
        check("t4_hit_stall", {31'h0, cache_stall}, 32'h0);
        check("t4_hit_rd", rd_data_out, 32'h1000_0784);
        drive(CACHE_RD_W, CACHE_WR_NO, 32'h384, 32'h0);
        wait_ready("t4_ready");
        check("t4_rd", rd_data_out, 32'h1000_0384);
        check("t4_nxfer", log_addr.size(), 32'd4);

        // 5: reset after two refill acks aborts the fill
        clear_log();
        drive(CACHE_RD_W, CACHE_WR_NO, 32'h584, 32'h0);
        check("t5_stall", {31'h0, cache_stall}, 32'h1);
        for (int n = 0; n < 100 && log_addr.size() < 2; n++) begin
            @(negedge clk);
            #1;
        end
        check("t5_two", log_addr.size(), 32'd2);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("t5_req", {31'h0, mem_req}, 32'h0);
        check("t5_rstall", {31'h0, cache_stall}, 32'h0);
        drive(CACHE_RD_W, CACHE_WR_NO, 32'h384, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("t5_miss", {31'h0, cache_stall}, 32'h1);
        wait_ready("t5_ready");
        check("t5_rd", rd_data_out, 32'h1000_0384);

        // 6: read returns pre-write data, write lands at the edge
        drive(CACHE_RD_HU, CACHE_WR_H, 32'h386, 32'hAABB_CCDD);
        check("t6_rd_old", rd_data_out, 32'h0000_1000);
        check("t6_stall", {31'h0, cache_stall}, 32'h0);
        drive(CACHE_RD_W, CACHE_WR_NO, 32'h384, 32'h0);
        check("t6_rd_new", rd_data_out, 32'hCCDD_0384);
        drive(CACHE_RD_NO, CACHE_WR_NO, 32'h384, 32'h0);
        check("t6_idle_rd", rd_data_out, 32'h0);
        check("t6_idle_stall", {31'h0, cache_stall}, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
